// File: rtl/alu_issue_unit_pkg.sv
// alu_issue_unit_pkg
//   Shared types for the ALU issue path in the frost32 execute stage.
//   - Port structs for the external combinational Alu (port_in_alu_t/port_out_alu_t).
//   - Request/response bundles for the issue unit.
//   - Operation encodings and FSM state constants.
//   - is_reserved_oper(): flags encodings the Alu does not implement.
package alu_issue_unit_pkg;

   localparam int ALU_WIDTH      = 32;
   localparam int ALU_OPER_WIDTH = 4;
   localparam int ALU_TAG_WIDTH  = 5;

   localparam logic [3:0] OPER_ADD  = 4'd0;
   localparam logic [3:0] OPER_SUB  = 4'd1;
   localparam logic [3:0] OPER_SLTU = 4'd2;
   localparam logic [3:0] OPER_SLTS = 4'd3;
   localparam logic [3:0] OPER_SGTU = 4'd4;
   localparam logic [3:0] OPER_SGTS = 4'd5;
   localparam logic [3:0] OPER_ANDN = 4'd6;
   localparam logic [3:0] OPER_AND  = 4'd7;
   localparam logic [3:0] OPER_OR   = 4'd8;
   localparam logic [3:0] OPER_XOR  = 4'd9;
   localparam logic [3:0] OPER_NOR  = 4'd10;
   localparam logic [3:0] OPER_LSL  = 4'd11;
   localparam logic [3:0] OPER_LSR  = 4'd12;
   localparam logic [3:0] OPER_ASR  = 4'd13;
   localparam logic [3:0] OPER_ORN  = 4'd14;
   localparam logic [3:0] OPER_NAND = 4'd15;

   // Issue FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic [ALU_OPER_WIDTH-1:0] oper;
      logic [ALU_WIDTH-1:0]      a;
      logic [ALU_WIDTH-1:0]      b;
   } port_in_alu_t;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] data;
   } port_out_alu_t;

   typedef struct packed {
      logic [ALU_OPER_WIDTH-1:0] oper;
      logic [ALU_WIDTH-1:0]      a;
      logic [ALU_WIDTH-1:0]      b;
      logic [ALU_TAG_WIDTH-1:0]  tag;
   } port_in_alu_req_t;

   typedef struct packed {
      logic [ALU_WIDTH-1:0]     data;
      logic [ALU_TAG_WIDTH-1:0] tag;
      logic                     illegal;
   } port_out_alu_rsp_t;

   // Encodings with no Alu implementation; the unit answers these itself.
   function automatic logic is_reserved_oper(input logic [ALU_OPER_WIDTH-1:0] oper);
      case (oper)
         OPER_SGTU, OPER_SGTS, OPER_ANDN, OPER_ORN, OPER_NAND: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Initiator side of the Alu interface. Accepts decoded ALU requests, drives
//   the external combinational Alu, holds its inputs for SETTLE_CYCLES and
//   registers the result into a tagged response for writeback.
//
// Ports
//   clk, rst_n         core clock, asynchronous active-low reset
//   flush              synchronous pipeline flush, drops any in-flight op
//   req_valid/ready    request handshake; req_oper/req_a/req_b/req_tag payload
//   alu_in             {oper,a,b} to the Alu instance, changes only on accept
//   alu_out            result from the Alu instance
//   rsp_valid/ready    response handshake; rsp_data/rsp_tag/rsp_illegal payload
//   ops_done           retired response count, wraps
//   dbg_state          current FSM state (ST_* constants)
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until that edge; ready may depend combinationally on the consumer's
// ready (req_ready follows rsp_ready in RESP) but never on valid.
module alu_issue_unit
   import alu_issue_unit_pkg::*;
#(
   parameter int WIDTH         = ALU_WIDTH,
   parameter int OPER_WIDTH    = ALU_OPER_WIDTH,
   parameter int TAG_WIDTH     = ALU_TAG_WIDTH,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [OPER_WIDTH-1:0] req_oper,
   input  logic [WIDTH-1:0]      req_a,
   input  logic [WIDTH-1:0]      req_b,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output port_in_alu_t          alu_in,
   input  port_out_alu_t         alu_out,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [TAG_WIDTH-1:0]  rsp_tag,
   output logic                  rsp_illegal,
   output logic [31:0]           ops_done,
   output logic [1:0]            dbg_state
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   logic [1:0]           state;
   logic [3:0]           cnt;
   logic [TAG_WIDTH-1:0] tag_q;
   port_out_alu_rsp_t    rsp_q;
   logic                 rsp_valid_q;
   logic [31:0]          ops_q;
   port_in_alu_req_t     req;
   logic                 accept;
   logic                 handshake;

   assign req = '{oper: req_oper, a: req_a, b: req_b, tag: req_tag};

   // Ready is forced low while reset is held and during a flush cycle, so no
   // transfer is ever advertised that the FSM would then discard.
   always_comb begin
      req_ready = 1'b0;
      case (state)
         ST_IDLE: req_ready = 1'b1;
         ST_RESP: req_ready = rsp_ready;
         default: req_ready = 1'b0;
      endcase
      req_ready = req_ready && rst_n && !flush;
   end

   assign accept    = req_valid && req_ready;
   assign handshake = rsp_valid_q && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         tag_q       <= '0;
         alu_in      <= '0;
         rsp_q       <= '0;
         rsp_valid_q <= 1'b0;
         ops_q       <= '0;
      end else if (flush) begin
         // Alu inputs and last response payload are deliberately left alone.
         state       <= ST_IDLE;
         rsp_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            // Taken from IDLE, or from RESP in the same edge as the response
            // handshake (back-to-back issue).
            alu_in <= '{oper: req.oper, a: req.a, b: req.b};
            tag_q  <= req.tag;
            cnt    <= CNT_INIT;
            if (is_reserved_oper(req.oper)) begin
               state       <= ST_RESP;
               rsp_valid_q <= 1'b1;
               rsp_q       <= '{data: '0, tag: req.tag, illegal: 1'b1};
            end else begin
               state       <= ST_EXEC;
               rsp_valid_q <= 1'b0;
            end
         end else begin
            case (state)
               ST_EXEC: begin
                  if (cnt == 4'd0) begin
                     rsp_q       <= '{data: alu_out.data, tag: tag_q, illegal: 1'b0};
                     rsp_valid_q <= 1'b1;
                     state       <= ST_RESP;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
               ST_RESP: begin
                  if (handshake) begin
                     rsp_valid_q <= 1'b0;
                     state       <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
         if (handshake) begin
            ops_q <= ops_q + 32'd1;
         end
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_q.data;
   assign rsp_tag     = rsp_q.tag;
   assign rsp_illegal = rsp_q.illegal;
   assign ops_done    = ops_q;
   assign dbg_state   = state;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
//   Bench for alu_issue_unit: a SETTLE_CYCLES=1 instance driven by a vector
//   table plus hand sequences, and a SETTLE_CYCLES=3 instance for reset
//   mid-execution. A behavioural Alu sits beside each instance.
module tb_alu_issue_unit;
   import alu_issue_unit_pkg::*;

   localparam int W_EXP = 38;   // {illegal, tag[4:0], data[31:0]}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, d3_rst_n;

   // ---------------- DUT (SETTLE_CYCLES=1) ----------------
   logic          flush, req_valid, req_ready, rsp_valid, rsp_ready, rsp_illegal;
   logic [3:0]    req_oper;
   logic [31:0]   req_a, req_b, rsp_data, ops_done;
   logic [4:0]    req_tag, rsp_tag;
   logic [1:0]    dbg_state;
   port_in_alu_t  alu_in;
   port_out_alu_t alu_out;

   // ---------------- DUT (SETTLE_CYCLES=3) ----------------
   logic          d3_flush, d3_req_valid, d3_req_ready, d3_rsp_valid, d3_rsp_ready, d3_rsp_illegal;
   logic [3:0]    d3_req_oper;
   logic [31:0]   d3_req_a, d3_req_b, d3_rsp_data, d3_ops_done;
   logic [4:0]    d3_req_tag, d3_rsp_tag;
   logic [1:0]    d3_dbg_state;
   port_in_alu_t  d3_alu_in;
   port_out_alu_t d3_alu_out;

   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OPER_ADD:  return a + b;
         OPER_SUB:  return a - b;
         OPER_SLTU: return {31'b0, a < b};
         OPER_SLTS: return {31'b0, $signed(a) < $signed(b)};
         OPER_SGTU: return {31'b0, a > b};
         OPER_SGTS: return {31'b0, $signed(a) > $signed(b)};
         OPER_ANDN: return a & ~b;
         OPER_AND:  return a & b;
         OPER_OR:   return a | b;
         OPER_XOR:  return a ^ b;
         OPER_NOR:  return ~(a | b);
         OPER_LSL:  return a << b;
         OPER_LSR:  return a >> b;
         OPER_ASR:  return $signed(a) >>> b;
         OPER_ORN:  return a | ~b;
         default:   return ~(a & b);
      endcase
   endfunction

   assign alu_out.data    = alu_model(alu_in.oper, alu_in.a, alu_in.b);
   assign d3_alu_out.data = alu_model(d3_alu_in.oper, d3_alu_in.a, d3_alu_in.b);

   alu_issue_unit #(.SETTLE_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_oper(req_oper),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .alu_in(alu_in), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .ops_done(ops_done),
      .dbg_state(dbg_state)
   );

   alu_issue_unit #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(d3_rst_n), .flush(d3_flush),
      .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_oper(d3_req_oper),
      .req_a(d3_req_a), .req_b(d3_req_b), .req_tag(d3_req_tag),
      .alu_in(d3_alu_in), .alu_out(d3_alu_out),
      .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_data(d3_rsp_data),
      .rsp_tag(d3_rsp_tag), .rsp_illegal(d3_rsp_illegal), .ops_done(d3_ops_done),
      .dbg_state(d3_dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [W_EXP-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_ops = 32'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W_EXP-1:0] mk_exp(input logic ill, input logic [4:0] tag, input logic [31:0] data);
      return {ill, tag, data};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [W_EXP-1:0] exp, input bit push);
      int waited = 0;
      req_oper  = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      req_valid = 1'b1;
      while (!req_ready && waited < 20) begin
         tick();
         waited++;
      end
      check("issue_ready", 64'(req_ready), 64'd1);
      if (push) exp_q.push_back(exp);
      tick();
      req_valid = 1'b0;
   endtask

   // Counts edges from the accept edge until rsp_valid is seen, then checks payload.
   task automatic wait_rsp(input string name, input int exp_lat);
      int lat = 0;
      logic [W_EXP-1:0] exp;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({name, "_data"}, 64'(rsp_data), 64'(exp[31:0]));
      check({name, "_tag"}, 64'(rsp_tag), 64'(exp[36:32]));
      check({name, "_illegal"}, 64'(rsp_illegal), 64'(exp[37]));
   endtask

   task automatic retire(input string name);
      tick();
      exp_ops = exp_ops + 32'd1;
      check({name, "_ops_done"}, 64'(ops_done), 64'(exp_ops));
      check({name, "_valid_drop"}, 64'(rsp_valid), 64'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  oper;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [31:0] exp_data;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [3:0]  bb_op[3];
      logic [31:0] bb_a[3], bb_b[3], bb_exp[3];
      int lat3;
      int seen;

      vecs[0]  = '{OPER_ADD,  32'hFFFF_FFFF, 32'd1,         5'd3,  32'h0000_0000, 1'b0};
      vecs[1]  = '{OPER_SLTU, 32'd1,         32'd2,         5'd1,  32'h0000_0001, 1'b0};
      vecs[2]  = '{OPER_SLTS, 32'hFFFF_FFFF, 32'd1,         5'd2,  32'h0000_0001, 1'b0};
      vecs[3]  = '{OPER_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4,  32'hF000_F000, 1'b0};
      vecs[4]  = '{OPER_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd5,  32'hF0F0_0F0F, 1'b0};
      vecs[5]  = '{OPER_NOR,  32'h0000_FFFF, 32'h00FF_0000, 5'd6,  32'hFF00_0000, 1'b0};
      vecs[6]  = '{OPER_LSR,  32'h8000_0000, 32'd4,         5'd7,  32'h0800_0000, 1'b0};
      vecs[7]  = '{OPER_LSL,  32'd1,         32'd32,        5'd8,  32'h0000_0000, 1'b0};
      vecs[8]  = '{OPER_SUB,  32'd0,         32'd1,         5'd9,  32'hFFFF_FFFF, 1'b0};
      vecs[9]  = '{OPER_NAND, 32'd0,         32'd0,         5'd15, 32'h0000_0000, 1'b1};
      vecs[10] = '{OPER_SGTU, 32'd5,         32'd1,         5'd16, 32'h0000_0000, 1'b1};
      vecs[11] = '{OPER_ANDN, 32'hFFFF_FFFF, 32'd0,         5'd17, 32'h0000_0000, 1'b1};
      vecs[12] = '{OPER_ORN,  32'd0,         32'd0,         5'd31, 32'h0000_0000, 1'b1};

      // ---- reset ----
      rst_n = 1'b0; d3_rst_n = 1'b0;
      flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_oper = '0; req_a = '0; req_b = '0; req_tag = '0;
      d3_flush = 1'b0; d3_req_valid = 1'b0; d3_rsp_ready = 1'b1;
      d3_req_oper = '0; d3_req_a = '0; d3_req_b = '0; d3_req_tag = '0;
      repeat (3) tick();
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
      check("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
      check("rst_ops_done", 64'(ops_done), 64'd0);
      check("rst_alu_in", 64'(alu_in.oper) | 64'(alu_in.a) | 64'(alu_in.b), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      rst_n = 1'b1; d3_rst_n = 1'b1;
      tick();
      check("post_rst_req_ready", 64'(req_ready), 64'd1);

      // ---- table vectors, rsp_ready held high ----
      rsp_ready = 1'b1;
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].oper, vecs[i].a, vecs[i].b, vecs[i].tag,
               mk_exp(vecs[i].exp_ill, vecs[i].tag, vecs[i].exp_data), 1'b1);
         wait_rsp($sformatf("vec%0d", i), vecs[i].exp_ill ? 0 : 1);
         retire($sformatf("vec%0d", i));
      end

      // ---- back-to-back: Sub, Lsl, Asr, one response every 2 cycles ----
      bb_op[0] = OPER_SUB; bb_a[0] = 32'd10;        bb_b[0] = 32'd3;  bb_exp[0] = 32'd7;
      bb_op[1] = OPER_LSL; bb_a[1] = 32'd1;         bb_b[1] = 32'd4;  bb_exp[1] = 32'd16;
      bb_op[2] = OPER_ASR; bb_a[2] = 32'h8000_0000; bb_b[2] = 32'd31; bb_exp[2] = 32'hFFFF_FFFF;
      req_oper = bb_op[0]; req_a = bb_a[0]; req_b = bb_b[0]; req_tag = 5'd20;
      req_valid = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bb%0d_gap", i), 64'(rsp_valid), 64'd0);
         if (i < 2) begin
            req_oper = bb_op[i+1]; req_a = bb_a[i+1]; req_b = bb_b[i+1]; req_tag = 5'(21 + i);
            req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         tick();
         check($sformatf("bb%0d_valid", i), 64'(rsp_valid), 64'd1);
         check($sformatf("bb%0d_data", i), 64'(rsp_data), 64'(bb_exp[i]));
         check($sformatf("bb%0d_tag", i), 64'(rsp_tag), 64'(20 + i));
         check($sformatf("bb%0d_req_ready", i), 64'(req_ready), 64'd1);
         tick();
      end
      exp_ops = exp_ops + 32'd3;
      check("bb_ops_done", 64'(ops_done), 64'(exp_ops));
      check("bb_idle", 64'(dbg_state), 64'(ST_IDLE));

      // ---- backpressure: Sltu 1,2 held for 5 cycles ----
      rsp_ready = 1'b0;
      issue(OPER_SLTU, 32'd1, 32'd2, 5'd7, mk_exp(1'b0, 5'd7, 32'd1), 1'b1);
      wait_rsp("bp", 1);
      req_oper = OPER_ADD; req_a = 32'd100; req_b = 32'd200; req_tag = 5'd9;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 64'(rsp_valid), 64'd1);
         check("bp_data", 64'(rsp_data), 64'd1);
         check("bp_tag", 64'(rsp_tag), 64'd7);
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_alu_in_oper", 64'(alu_in.oper), 64'(OPER_SLTU));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      retire("bp");

      // ---- flush during EXEC of Xor ----
      issue(OPER_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd10, '0, 1'b0);
      check("fl_in_exec", 64'(dbg_state), 64'(ST_EXEC));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_valid", 64'(rsp_valid), 64'd0);
      check("fl_state", 64'(dbg_state), 64'(ST_IDLE));
      check("fl_ops_done", 64'(ops_done), 64'(exp_ops));
      check("fl_alu_in_a", 64'(alu_in.a), 64'hFFFF_0000);
      check("fl_alu_in_oper", 64'(alu_in.oper), 64'(OPER_XOR));
      for (int i = 0; i < 2; i++) begin
         tick();
         check("fl_valid_stays_low", 64'(rsp_valid), 64'd0);
      end
      issue(OPER_OR, 32'h0F0F_0000, 32'h0000_00F0, 5'd11, mk_exp(1'b0, 5'd11, 32'h0F0F_00F0), 1'b1);
      wait_rsp("after_flush", 1);
      retire("after_flush");

      // flush in IDLE with a pending request: nothing accepted
      req_oper = OPER_SUB; req_a = 32'd1; req_b = 32'd1; req_tag = 5'd12;
      req_valid = 1'b1; flush = 1'b1;
      tick();
      req_valid = 1'b0; flush = 1'b0;
      check("fl_idle_no_accept_state", 64'(dbg_state), 64'(ST_IDLE));
      check("fl_idle_no_accept_alu_in", 64'(alu_in.oper), 64'(OPER_OR));
      check("fl_idle_no_accept_valid", 64'(rsp_valid), 64'd0);

      // ---- SETTLE_CYCLES=3: normal op, then reset mid-EXEC ----
      d3_req_oper = OPER_ADD; d3_req_a = 32'd5; d3_req_b = 32'd6; d3_req_tag = 5'd2;
      d3_req_valid = 1'b1;
      tick();
      d3_req_valid = 1'b0;
      lat3 = 0;
      while (!d3_rsp_valid && lat3 < 20) begin
         tick();
         lat3++;
      end
      check("s3_latency", 64'(lat3), 64'd3);
      check("s3_data", 64'(d3_rsp_data), 64'd11);
      check("s3_tag", 64'(d3_rsp_tag), 64'd2);
      tick();
      check("s3_ops_done", 64'(d3_ops_done), 64'd1);

      d3_req_oper = OPER_SUB; d3_req_a = 32'd9; d3_req_b = 32'd4; d3_req_tag = 5'd3;
      d3_req_valid = 1'b1;
      tick();
      d3_req_valid = 1'b0;
      tick();
      check("s3_mid_exec", 64'(d3_dbg_state), 64'(ST_EXEC));
      #2 d3_rst_n = 1'b0;
      #1;
      check("s3_rst_valid", 64'(d3_rsp_valid), 64'd0);
      check("s3_rst_data", 64'(d3_rsp_data), 64'd0);
      check("s3_rst_tag", 64'(d3_rsp_tag), 64'd0);
      check("s3_rst_ops_done", 64'(d3_ops_done), 64'd0);
      check("s3_rst_alu_in", 64'(d3_alu_in.oper) | 64'(d3_alu_in.a) | 64'(d3_alu_in.b), 64'd0);
      check("s3_rst_req_ready", 64'(d3_req_ready), 64'd0);
      check("s3_rst_state", 64'(d3_dbg_state), 64'(ST_IDLE));
      tick();
      d3_rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (d3_rsp_valid) seen++;
      end
      check("s3_no_rsp_after_rst", 64'(seen), 64'd0);
      check("s3_ops_after_rst", 64'(d3_ops_done), 64'd0);
      check("s3_ready_after_rst", 64'(d3_req_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
